ctrl_fsm: RTL and testbench
===========================

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The ports SHALL be exactly:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- mem_rdata  in  32  memory read word; [31:26] is the opcode
- mem_ready  in  1  memory completes the current request this cycle
- zf  in  1  ALU zero flag
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- iord  out  1  address select: 0 = PC, 1 = alu_out
- ir_we  out  1  instruction register load
- mdr_we  out  1  memory data register load
- pc_we  out  1  PC load
- pc_sel  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = alu_out
- alu_op  out  6  ALU opcode, using the shared def.v encodings
- alu_b_imm  out  1  ALU B operand: 1 = sign-extended imm, 0 = rt
- reg_we  out  1  register file write
- reg_dst_rd  out  1  write destination: 1 = rd, 0 = rt
- wb_mem  out  1  write-back source: 1 = MDR, 0 = alu_out
- illegal  out  1  one-cycle pulse on an unknown opcode
- state  out  3  current state, for debug

Function
REQ-003 The states SHALL be encoded RST = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5; codes 6 and 7 SHALL go to RST on the next edge.
REQ-004 An internal 6-bit op register SHALL load mem_rdata[31:26] on every cycle in which ir_we = 1.
REQ-005 All outputs not listed for a state SHALL be 0; outputs SHALL be combinational from state, op, mem_ready and zf.
REQ-006 RST: all outputs 0 (alu_op = 0); the next state SHALL be FETCH unconditionally.
REQ-007 FETCH: mem_req = 1, iord = 0, alu_op = ADD.
- mem_ready = 0: stay in FETCH.
- mem_ready = 1: ir_we = 1, pc_we = 1, pc_sel = 00, next state DECODE.
REQ-008 DECODE: alu_op = ADD.
- op in {LDW, SDW, BEQ, ADD, SUB, AND, OR, XOR, SLT, JUMP}: next state EXEC.
- otherwise: illegal = 1 for this cycle only, next state FETCH; no other side effect.
REQ-009 EXEC: alu_op = op; alu_b_imm = 1 for LDW/SDW, else 0.
- BEQ: pc_we = zf, pc_sel = 01, next state FETCH.
- JUMP: pc_we = 1, pc_sel = 10, next state FETCH.
- LDW/SDW: next state MEM.
- ADD/SUB/AND/OR/XOR/SLT: next state WB.
REQ-010 MEM: mem_req = 1, iord = 1, alu_op = op, alu_b_imm = 1, mem_we = 1 if op = SDW.
- mem_ready = 0: stay in MEM, all outputs held.
- mem_ready = 1 and LDW: mdr_we = 1, next state WB.
- mem_ready = 1 and SDW: next state FETCH.
REQ-011 WB: reg_we = 1 for exactly one cycle; alu_op = op.
- LDW: reg_dst_rd = 0, wb_mem = 1, alu_b_imm = 1.
- R-ops: reg_dst_rd = 1, wb_mem = 0.
- next state FETCH.
REQ-012 mem_ready SHALL be ignored in every state other than FETCH and MEM.
REQ-013 Latency with zero-wait memory SHALL be: R-op 4 cycles, LDW 5, SDW 4, BEQ 3, JUMP 3, illegal 2; each wait cycle adds 1.
REQ-014 reg_we, pc_we and mem_we SHALL never be asserted in the same cycle.

Reset
REQ-015 rst_n low SHALL force state = RST and op = 0 asynchronously; all outputs SHALL be 0 within the same cycle, including a reset asserted mid-FETCH or mid-MEM with mem_req high.
REQ-016 After rst_n is released, the first edge SHALL move RST to FETCH; mem_req first rises in the cycle after release.

Verification
REQ-017 ADD instruction, mem_ready held 1 -> state sequence 1, 2, 3, 5, 1; reg_we = 1 and reg_dst_rd = 1 in WB only; pc_we = 1 in FETCH only.
REQ-018 LDW with mem_ready low for 2 cycles in MEM -> MEM is held 3 cycles with mem_req = 1 and iord = 1; mdr_we pulses once; WB has wb_mem = 1 and reg_dst_rd = 0; total 7 cycles.
REQ-019 BEQ -> with zf = 1, EXEC has pc_we = 1 and pc_sel = 01; with zf = 0, pc_we = 0; both cases return to FETCH after 3 cycles with reg_we never set.
REQ-020 SDW, then opcode 6'h3F -> SDW: mem_we = 1 in MEM only, reg_we never set. 6'h3F: illegal = 1 for one cycle in DECODE, next state FETCH, no reg_we/pc_we/mem_we.
REQ-021 rst_n pulled low during MEM of an SDW with mem_ready = 0 -> mem_req and mem_we drop to 0 immediately and state = 0; after release, state 1 follows on the next edge.

Source files
------------

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm
// Description : Multi-cycle processor control FSM. It sequences instruction
//               fetch, decode, execute, memory access and write-back, and
//               drives the datapath control strobes from these steps.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        zf,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [5:0]  alu_op,
    output logic        alu_b_imm,
    output logic        reg_we,
    output logic        reg_dst_rd,
    output logic        wb_mem,
    output logic        illegal,
    output logic [2:0]  state
);

    // Opcode encodings shared with the ALU and the instruction set
    localparam logic [5:0] OP_JUMP = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_XOR  = 6'h26;
    localparam logic [5:0] OP_SLT  = 6'h2A;
    localparam logic [5:0] OP_LDW  = 6'h23;
    localparam logic [5:0] OP_SDW  = 6'h2B;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       w_legal;
    logic       unused_rdata;

    // Only the opcode field of the fetched word is consumed here
    assign unused_rdata = ^mem_rdata[25:0];
    assign state        = state_q;

    // Classify the latched opcode as a supported instruction
    always_comb begin
        w_legal = 1'b0;
        case (op_q)
            OP_LDW, OP_SDW, OP_BEQ, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR, OP_SLT, OP_JUMP: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
        endcase
    end

    // Next-state and control-strobe decode from state, opcode, ready and zero flag
    always_comb begin
        state_d    = S_RST;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        alu_op     = 6'd0;
        alu_b_imm  = 1'b0;
        reg_we     = 1'b0;
        reg_dst_rd = 1'b0;
        wb_mem     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                alu_op  = OP_ADD;
                if (mem_ready) begin
                    // Latch the instruction and advance PC by 4 together
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_op = OP_ADD;
                if (w_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_op = op_q;
                case (op_q)
                    OP_BEQ: begin
                        pc_we   = zf;
                        pc_sel  = PC_BRANCH;
                        state_d = S_FETCH;
                    end
                    OP_JUMP: begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_ALU;
                        state_d = S_FETCH;
                    end
                    OP_LDW, OP_SDW: begin
                        alu_b_imm = 1'b1;
                        state_d   = S_MEM;
                    end
                    default: begin
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                alu_op    = op_q;
                alu_b_imm = 1'b1;
                mem_we    = (op_q == OP_SDW);
                if (!mem_ready) begin
                    state_d = S_MEM;
                end else if (op_q == OP_SDW) begin
                    state_d = S_FETCH;
                end else begin
                    mdr_we  = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                alu_op = op_q;
                if (op_q == OP_LDW) begin
                    wb_mem    = 1'b1;
                    alu_b_imm = 1'b1;
                end else begin
                    reg_dst_rd = 1'b1;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // State and opcode registers; reset forces RST and a zero opcode immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (ir_we) begin
                op_q <= mem_rdata[31:26];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_fsm
// Description : Self-checking bench for ctrl_fsm. Each scenario queues its
//               per-cycle stimulus and expected outputs, then replays them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

    localparam logic [5:0] OP_JUMP = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_XOR  = 6'h26;
    localparam logic [5:0] OP_SLT  = 6'h2A;
    localparam logic [5:0] OP_LDW  = 6'h23;
    localparam logic [5:0] OP_SDW  = 6'h2B;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       iord;
        logic       irwe;
        logic       mdrwe;
        logic       pcwe;
        logic [1:0] pcsel;
        logic [5:0] aop;
        logic       bimm;
        logic       regwe;
        logic       rdst;
        logic       wbmem;
        logic       ill;
    } out_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rdy;
        logic        zf;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        zf;
    logic        mem_req, mem_we, iord, ir_we, mdr_we, pc_we;
    logic [1:0]  pc_sel;
    logic [5:0]  alu_op;
    logic        alu_b_imm, reg_we, reg_dst_rd, wb_mem, illegal;
    logic [2:0]  state;
    out_t        dut_o;

    int total = 0;
    int bad   = 0;

    stim_t stim_q[$];
    out_t  exp_q[$];

    ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .zf         (zf),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .mdr_we     (mdr_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .alu_op     (alu_op),
        .alu_b_imm  (alu_b_imm),
        .reg_we     (reg_we),
        .reg_dst_rd (reg_dst_rd),
        .wb_mem     (wb_mem),
        .illegal    (illegal),
        .state      (state)
    );

    assign dut_o = {state, mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pc_sel,
                    alu_op, alu_b_imm, reg_we, reg_dst_rd, wb_mem, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-output builders for each state, written from the requirements
    function automatic out_t e_fetch(input logic rdy);
        out_t e = '0;
        e.st = 3'd1; e.req = 1'b1; e.aop = OP_ADD;
        if (rdy) begin e.irwe = 1'b1; e.pcwe = 1'b1; e.pcsel = 2'b00; end
        return e;
    endfunction

    function automatic out_t e_decode(input logic ill);
        out_t e = '0;
        e.st = 3'd2; e.aop = OP_ADD; e.ill = ill;
        return e;
    endfunction

    function automatic out_t e_exec(input logic [5:0] op, input logic z);
        out_t e = '0;
        e.st = 3'd3; e.aop = op;
        if (op == OP_LDW || op == OP_SDW) e.bimm = 1'b1;
        if (op == OP_BEQ)  begin e.pcwe = z;    e.pcsel = 2'b01; end
        if (op == OP_JUMP) begin e.pcwe = 1'b1; e.pcsel = 2'b10; end
        return e;
    endfunction

    function automatic out_t e_mem(input logic [5:0] op, input logic rdy);
        out_t e = '0;
        e.st = 3'd4; e.req = 1'b1; e.iord = 1'b1; e.aop = op; e.bimm = 1'b1;
        e.we = (op == OP_SDW);
        e.mdrwe = rdy && (op == OP_LDW);
        return e;
    endfunction

    function automatic out_t e_wb(input logic [5:0] op);
        out_t e = '0;
        e.st = 3'd5; e.regwe = 1'b1; e.aop = op;
        if (op == OP_LDW) begin e.wbmem = 1'b1; e.bimm = 1'b1; end
        else              e.rdst = 1'b1;
        return e;
    endfunction

    task automatic push(input logic [31:0] rd, input logic rdy, input logic z, input out_t e);
        stim_q.push_back({rd, rdy, z});
        exp_q.push_back(e);
    endtask

    // Replay queued cycles: drive just after posedge, check at negedge
    task automatic run(input string name);
        stim_t s;
        out_t  e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            mem_rdata = s.rdata;
            mem_ready = s.rdy;
            zf        = s.zf;
            @(negedge clk);
            total++;
            if (dut_o !== e) begin
                bad++;
                $display("FAIL %s: got %h expected %h (t=%0t)", name, dut_o, e, $time);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_rdata = '0; mem_ready = 1'b1; zf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dut_o !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", dut_o);
        end
        rst_n = 1'b1;
        // The cycle right after release still shows RST with mem_req low
        push(32'h0, 1'b1, 1'b0, out_t'('0));
        run("reset_release");
    endtask

    task automatic test_add();
        push({OP_ADD, 26'h155_5555}, 1'b1, 1'b0, e_fetch(1'b1));
        push(32'hFFFF_FFFF, 1'b0, 1'b1, e_decode(1'b0));
        push(32'h0, 1'b1, 1'b0, e_exec(OP_ADD, 1'b0));
        push(32'h0, 1'b0, 1'b1, e_wb(OP_ADD));
        run("add");
    endtask

    task automatic test_rops();
        logic [5:0] ops [5] = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT};
        for (int i = 0; i < 5; i++) begin
            push({ops[i], 26'($urandom)}, 1'b1, 1'b0, e_fetch(1'b1));
            push(32'h0, 1'($urandom), 1'b0, e_decode(1'b0));
            push(32'h0, 1'($urandom), 1'b1, e_exec(ops[i], 1'b1));
            push(32'h0, 1'($urandom), 1'b0, e_wb(ops[i]));
        end
        run("rops");
    endtask

    task automatic test_ldw_wait();
        push({OP_LDW, 26'h0}, 1'b1, 1'b0, e_fetch(1'b1));
        push(32'h0, 1'b1, 1'b0, e_decode(1'b0));
        push(32'h0, 1'b1, 1'b0, e_exec(OP_LDW, 1'b0));
        push(32'h0, 1'b0, 1'b0, e_mem(OP_LDW, 1'b0));
        push(32'h0, 1'b0, 1'b0, e_mem(OP_LDW, 1'b0));
        push(32'h0, 1'b1, 1'b0, e_mem(OP_LDW, 1'b1));
        push(32'h0, 1'b1, 1'b0, e_wb(OP_LDW));
        run("ldw_wait");
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            push({OP_BEQ, 26'h3}, 1'b1, 1'(z), e_fetch(1'b1));
            push(32'h0, 1'b1, 1'(z), e_decode(1'b0));
            push(32'h0, 1'b1, 1'(z), e_exec(OP_BEQ, 1'(z)));
        end
        run("beq");
    endtask

    task automatic test_jump_fetch_wait();
        push({OP_JUMP, 26'h0}, 1'b0, 1'b0, e_fetch(1'b0));
        push({OP_JUMP, 26'h0}, 1'b0, 1'b0, e_fetch(1'b0));
        push({OP_JUMP, 26'h0}, 1'b1, 1'b0, e_fetch(1'b1));
        push(32'h0, 1'b0, 1'b0, e_decode(1'b0));
        push(32'h0, 1'b0, 1'b0, e_exec(OP_JUMP, 1'b0));
        run("jump_fetch_wait");
    endtask

    task automatic test_sdw_illegal();
        push({OP_SDW, 26'h0}, 1'b1, 1'b0, e_fetch(1'b1));
        push(32'h0, 1'b1, 1'b0, e_decode(1'b0));
        push(32'h0, 1'b1, 1'b0, e_exec(OP_SDW, 1'b0));
        push(32'h0, 1'b1, 1'b0, e_mem(OP_SDW, 1'b1));
        push({6'h3F, 26'h0}, 1'b1, 1'b0, e_fetch(1'b1));
        push(32'h0, 1'b1, 1'b1, e_decode(1'b1));
        run("sdw_illegal");
    endtask

    task automatic test_reset_mid_mem();
        push({OP_SDW, 26'h0}, 1'b1, 1'b0, e_fetch(1'b1));
        push(32'h0, 1'b1, 1'b0, e_decode(1'b0));
        push(32'h0, 1'b1, 1'b0, e_exec(OP_SDW, 1'b0));
        push(32'h0, 1'b0, 1'b0, e_mem(OP_SDW, 1'b0));
        run("sdw_mem_hold");
        // Still in MEM with mem_ready low; reset mid-cycle must clear at once
        mem_ready = 1'b0;
        #2;
        total++;
        if (dut_o !== e_mem(OP_SDW, 1'b0)) begin
            bad++;
            $display("FAIL mem_before_reset: got %h expected %h", dut_o, e_mem(OP_SDW, 1'b0));
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_o !== '0) begin
            bad++;
            $display("FAIL async_reset_mem: got %h expected 0", dut_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL released_still_rst: got state=%0d req=%b expected state=0 req=0", state, mem_req);
        end
        @(posedge clk);
        #1;
        total++;
        if (dut_o !== e_fetch(1'b1)) begin
            bad++;
            $display("FAIL fetch_after_reset: got %h expected %h", dut_o, e_fetch(1'b1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        zf = 1'b0;
        test_reset();
        test_add();
        test_rops();
        test_ldw_wait();
        test_beq();
        test_jump_fetch_wait();
        test_sdw_illegal();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
